// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake: 1-cycle ops, MUL takes WIDTH+1 edges; result held until out_ready.
// Optional macro ALU_ACC_EN lets use_acc substitute the held result for operand A.
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_z, r_n, r_c, r_v;
    logic [WIDTH-1:0]   r_prod, r_mcand, r_mplier;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_opa, w_opb, w_res, w_prod_next;
    logic [WIDTH:0]     w_sum;
    logic               w_cin, w_c, w_v, w_carry_msb;

`ifdef ALU_ACC_EN
    assign w_opa = use_acc ? r_result : a;
`else
    logic w_unused_acc;
    assign w_unused_acc = use_acc;
    assign w_opa = a;
`endif

    // One adder serves ADD, SUB (a + ~b + 1) and ADC (a + b + previous carry).
    assign w_opb = (op == OP_SUB) ? ~b : b;
    assign w_cin = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? r_c : 1'b0);
    assign w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    assign w_carry_msb = w_sum[WIDTH-1] ^ w_opa[WIDTH-1] ^ w_opb[WIDTH-1];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_carry_msb ^ w_sum[WIDTH];
            end
            OP_AND:  w_res = w_opa & b;
            OP_OR:   w_res = w_opa | b;
            OP_XOR:  w_res = w_opa ^ b;
            OP_PASS: w_res = w_opa;
            default: w_res = '0;
        endcase
    end

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            r_prod   <= '0;
                            r_mcand  <= w_opa;
                            r_mplier <= b;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_state  <= S_BUSY;
                        end else begin
                            r_result    <= w_res;
                            r_z         <= (w_res == '0);
                            r_n         <= w_res[WIDTH-1];
                            r_c         <= w_c;
                            r_v         <= w_v;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    // Last iteration: publish the finished product, never a partial one.
                    if (r_cnt == CNT_W'(1)) begin
                        r_result    <= w_prod_next;
                        r_z         <= (w_prod_next == '0);
                        r_n         <= w_prod_next[WIDTH-1];
                        r_c         <= 1'b0;
                        r_v         <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 4;
    localparam int M = 1 << W;
`ifdef ALU_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         use_acc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic         m_c   = 1'b0;
    logic [W-1:0] m_res = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .use_acc(use_acc),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; signed overflow from the signed-range test.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic cin, output logic [W-1:0] r, output logic z,
                                  output logic n, output logic c, output logic v);
        int sx, sy, s, ss;
        sx = (int'(x) >= M/2) ? int'(x) - M : int'(x);
        sy = (int'(y) >= M/2) ? int'(y) - M : int'(y);
        s = 0; ss = 0; c = 1'b0; v = 1'b0;
        case (o)
            3'd0: begin s = int'(x) + int'(y); ss = sx + sy; c = (s >= M); v = (ss > M/2-1) || (ss < -M/2); end
            3'd1: begin s = int'(x) - int'(y) + M; ss = sx - sy; c = (x >= y); v = (ss > M/2-1) || (ss < -M/2); end
            3'd2: s = int'(x & y);
            3'd3: s = int'(x | y);
            3'd4: s = int'(x ^ y);
            3'd5: s = int'(x);
            3'd6: begin s = int'(x) + int'(y) + int'(cin); ss = sx + sy + int'(cin); c = (s >= M); v = (ss > M/2-1) || (ss < -M/2); end
            default: s = int'(x) * int'(y);
        endcase
        r = W'(s % M);
        z = (r == '0);
        n = r[W-1];
    endfunction

    task automatic run_op(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          input logic t_acc, input int hold);
        int lat;
        bit rdy_seen;
        logic [W-1:0] ea, er;
        logic ez, en, ec, ev;
        logic [31:0] snap;
        lat = 0;
        while (!in_ready && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        ea = (ACC_EN && t_acc) ? m_res : t_a;
        model(t_op, ea, t_b, m_c, er, ez, en, ec, ev);
        in_valid = 1'b1; op = t_op; a = t_a; b = t_b; use_acc = t_acc; out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; the captured values must be used.
        in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom); use_acc = 1'($urandom);
        lat = 1; rdy_seen = 0;
        while (!out_valid && lat < 60) begin
            if (in_ready) rdy_seen = 1;
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), (t_op == 3'd7) ? 32'(W + 1) : 32'd1);
        chk("in_ready_low_while_busy", 32'(rdy_seen), 32'd0);
        chk("result", 32'(result), 32'(er));
        chk("flags_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'({ez, en, ec, ev}));
        chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
        snap = 32'({out_valid, in_ready, flag_z, flag_n, flag_c, flag_v, result});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_stable", 32'({out_valid, in_ready, flag_z, flag_n, flag_c, flag_v, result}), snap);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        m_c = ec;
        m_res = er;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);

        run_op(3'd0, 4'd7, 4'd9, 1'b0, 0);
        chk("add_7_9_exact", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'({4'd0, 4'b1010}));
        run_op(3'd0, 4'd7, 4'd1, 1'b0, 0);
        chk("add_7_1_exact", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'({4'd8, 4'b0101}));
        run_op(3'd1, 4'd3, 4'd5, 1'b0, 0);
        chk("sub_3_5_exact", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'({4'd14, 4'b0100}));
        run_op(3'd1, 4'd15, 4'd15, 1'b0, 0);
        run_op(3'd6, 4'd2, 4'd3, 1'b0, 5);
        chk("adc_2_3_exact", 32'({result, flag_c}), 32'({4'd6, 1'b0}));
        run_op(3'd7, 4'd5, 4'd3, 1'b0, 0);
        chk("mul_5_3_exact", 32'({result, flag_c}), 32'({4'd15, 1'b0}));
        run_op(3'd7, 4'd15, 4'd15, 1'b0, 2);
        chk("mul_15_15_exact", 32'(result), 32'd1);

        // Reset during the second BUSY cycle of a multiply.
        in_valid = 1'b1; op = 3'd7; a = 4'd6; b = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midbusy_rst_state", 32'({out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v}),
            32'({1'b0, 1'b1, 4'd0, 4'd0}));
        @(posedge clk); #1;
        reset = 1'b0;
        m_c = 1'b0; m_res = '0;
        run_op(3'd0, 4'd1, 4'd1, 1'b0, 0);
        chk("add_after_rst", 32'(result), 32'd2);

        run_op(3'd0, 4'd3, 4'd4, 1'b0, 0);
        if (ACC_EN) run_op(3'd0, 4'd9, 4'd5, 1'b1, 0);
        else        run_op(3'd0, 4'd0, 4'd5, 1'b1, 0);
        chk("acc_sequence", 32'(result), ACC_EN ? 32'd12 : 32'd5);

        for (int i = 0; i < 150; i++)
            run_op(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(2, 0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU. It adds a valid/ready operand handshake, registered result and flags, a carry-chained ADC op and an iterative shift-add multiply.
- Sits between the switch/IO input capture and the 7-segment/LED output logic in the tt_um_* top level.
- Result and flags are held until the consumer takes them.

Parameters:
- WIDTH, 4: operand and result width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH)+1: multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept a new operation
- op  input  3  operation code, see Behaviour
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- use_acc  input  1  replace A with last result (only when ALU_ACC_EN defined)
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- flag_z  output  1  result == 0
- flag_n  output  1  result[WIDTH-1]
- flag_c  output  1  carry out (ADD/ADC/SUB), else 0
- flag_v  output  1  signed overflow (ADD/ADC/SUB), else 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, internal carry flag 0, mul counter 0.
- Op codes:
  - 000 ADD: a+b, carry-in 0.
  - 001 SUB: a+~b+1; flag_c=1 means no borrow.
  - 010 AND, 011 OR, 100 XOR: bitwise on a and b.
  - 101 PASS: result=a.
  - 110 ADC: a+b+flag_c, using the flag_c registered by the previous completed op.
  - 111 MUL: low WIDTH bits of a*b, unsigned.
- flag_v = carry into MSB XOR carry out of MSB; flag_v is 0 for non-arithmetic ops. flag_c is 0 for logic, PASS and MUL.
- Accept: a transfer occurs when in_valid && in_ready on a rising edge. Operands and op are captured at that edge; later changes to the inputs are ignored.
- FSM:
  - IDLE (in_ready=1): accept a non-MUL op -> DONE, with result and flags registered at that same edge (1-cycle latency). Accept MUL -> BUSY, clear the accumulator, load counter=WIDTH.
  - BUSY (in_ready=0): each cycle, if multiplier LSB=1 add the shifted multiplicand to the product; shift multiplier right and multiplicand left; decrement counter. When the counter reaches 0, register result and flags -> DONE. MUL latency is WIDTH+1 edges from acceptance to out_valid.
  - DONE (out_valid=1, in_ready=0): outputs held stable. When out_ready=1, go to IDLE and drop out_valid at that edge. A back-to-back accept in the same cycle is not supported; in_ready goes high on the next cycle.
- out_valid and result never change while out_valid=1 && out_ready=0.
- Wrap-around: all arithmetic is modulo 2^WIDTH. MUL overflow bits are discarded silently.
- Reset asserted in any state, including mid-BUSY, aborts immediately to the reset values. A partial product is never presented.
- Unknown or X op: not possible, since all 8 codes are defined.

Optional Feature:
- Macro: ALU_ACC_EN.
- Defined: when use_acc=1 at accept, operand A is the currently held result register value instead of a. This enables chained accumulation such as repeated ADC for multi-word adds.
- Not defined: the use_acc port exists but is ignored; A always comes from a. No accumulator mux is synthesised.

Test Plan (WIDTH=4):
- Reset, then ADD a=7 b=9, out_ready=1 -> out_valid one cycle after accept; result=0, Z=1, C=1, N=0, V=0.
- ADD a=7 b=1 -> result=8, N=1, V=1, C=0. Then SUB a=3 b=5 -> result=14, N=1, C=0, V=0.
- SUB a=15 b=15 (sets C=1), then ADC a=2 b=3 -> result=6, C=0. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- MUL a=5 b=3 -> in_ready=0 for 4 cycles, out_valid on 5th edge, result=15, C=0. MUL a=15 b=15 -> result=1.
- Start MUL a=6 b=7, assert reset on the 2nd BUSY cycle -> out_valid=0, result=0, in_ready=1 immediately; a following ADD 1+1 -> 2.
- With ALU_ACC_EN: ADD 3+4 (result=7), then use_acc=1 ADD b=5 -> result=12; without the macro the same sequence with a=0 -> result=5.
